uart_bit_timer: RTL and testbench

UART_BIT_TIMER -- requirements
Module: uart_bit_timer

---
 rtl/uart_bit_timer.sv | 171 +++++++++++++++++
 tb/tb_uart_bit_timer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bit_timer.sv
// UART receive bit timer: paces start, data, parity and stop bit mid-point
// strobes for one frame, with the frame configuration captured at start.
module uart_bit_timer #(
   parameter  int unsigned CNT_W    = 14,
   parameter  int unsigned MAX_DATA = 9,
   localparam int unsigned IDX_W    = $clog2(MAX_DATA + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic             enable_timer,
   input  logic [CNT_W-1:0] bit_period,
   input  logic [IDX_W-1:0] data_size,
   input  logic             parity_en,
   input  logic             two_stop,
   output logic             start_strobe,
   output logic             shift_enable,
   output logic             parity_strobe,
   output logic             stop_strobe,
   output logic             packet_done,
   output logic [IDX_W-1:0] bit_index,
   output logic             busy
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t            state, state_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic [IDX_W-1:0]  idx_n;
   logic              stop_seen, stop_seen_n;

   // configuration captured when a frame is accepted
   logic [CNT_W-1:0]  per_q, per_n;
   logic [IDX_W-1:0]  size_q, size_n;
   logic              par_q, par_n;
   logic              two_q, two_n;

   logic              ss_n, sh_n, ps_n, st_n, pd_n, busy_n;

   logic [CNT_W-1:0]  eff_p;
   logic [CNT_W-1:0]  target;
   logic [IDX_W-1:0]  eff_d;
   logic              hit;

   // effective period/size and the phase-counter terminal decode
   always_comb begin
      eff_p  = (per_q < CNT_W'(2)) ? CNT_W'(2) : per_q;
      eff_d  = size_q;
      if (size_q == '0)
         eff_d = IDX_W'(1);
      else if (size_q > IDX_W'(MAX_DATA))
         eff_d = IDX_W'(MAX_DATA);
      target = (state == START) ? (eff_p >> 1) : eff_p;
      hit    = enable_timer && (cnt == (target - CNT_W'(1)));
   end

   // next-state, counter and strobe decode; abort overrides everything
   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      idx_n       = bit_index;
      stop_seen_n = stop_seen;
      per_n       = per_q;
      size_n      = size_q;
      par_n       = par_q;
      two_n       = two_q;
      ss_n        = 1'b0;
      sh_n        = 1'b0;
      ps_n        = 1'b0;
      st_n        = 1'b0;
      pd_n        = 1'b0;

      if (abort) begin
         state_n     = IDLE;
         cnt_n       = '0;
         idx_n       = '0;
         stop_seen_n = 1'b0;
      end else if (state == IDLE) begin
         if (start) begin
            state_n     = START;
            cnt_n       = '0;
            idx_n       = '0;
            stop_seen_n = 1'b0;
            per_n       = bit_period;
            size_n      = data_size;
            par_n       = parity_en;
            two_n       = two_stop;
         end
      end else if (enable_timer) begin
         if (!hit) begin
            cnt_n = cnt + CNT_W'(1);
         end else begin
            cnt_n = '0;
            case (state)
               START: begin
                  ss_n    = 1'b1;
                  state_n = DATA;
               end
               DATA: begin
                  sh_n  = 1'b1;
                  idx_n = bit_index + IDX_W'(1);
                  if (bit_index == (eff_d - IDX_W'(1)))
                     state_n = par_q ? PARITY : STOP;
               end
               PARITY: begin
                  ps_n    = 1'b1;
                  state_n = STOP;
               end
               STOP: begin
                  st_n = 1'b1;
                  if (!two_q || stop_seen) begin
                     pd_n        = 1'b1;
                     stop_seen_n = 1'b0;
                     state_n     = IDLE;
                  end else begin
                     stop_seen_n = 1'b1;
                  end
               end
               default: begin
                  state_n = IDLE;
               end
            endcase
         end
      end

      busy_n = (state_n != IDLE);
   end

   // state, counters, captured configuration and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         cnt           <= '0;
         bit_index     <= '0;
         stop_seen     <= 1'b0;
         per_q         <= '0;
         size_q        <= '0;
         par_q         <= 1'b0;
         two_q         <= 1'b0;
         start_strobe  <= 1'b0;
         shift_enable  <= 1'b0;
         parity_strobe <= 1'b0;
         stop_strobe   <= 1'b0;
         packet_done   <= 1'b0;
         busy          <= 1'b0;
      end else begin
         state         <= state_n;
         cnt           <= cnt_n;
         bit_index     <= idx_n;
         stop_seen     <= stop_seen_n;
         per_q         <= per_n;
         size_q        <= size_n;
         par_q         <= par_n;
         two_q         <= two_n;
         start_strobe  <= ss_n;
         shift_enable  <= sh_n;
         parity_strobe <= ps_n;
         stop_strobe   <= st_n;
         packet_done   <= pd_n;
         busy          <= busy_n;
      end
   end

endmodule

// File: tb/tb_uart_bit_timer.sv
// Directed bench for uart_bit_timer. Cycle k is the interval after the k-th
// rising edge counted from the edge that samples start (edge 0).
module tb_uart_bit_timer;

   logic        clk;
   logic        rst;
   logic        start;
   logic        abort;
   logic        enable_timer;
   logic [13:0] bit_period;
   logic [3:0]  data_size;
   logic        parity_en;
   logic        two_stop;
   logic        start_strobe;
   logic        shift_enable;
   logic        parity_strobe;
   logic        stop_strobe;
   logic        packet_done;
   logic [3:0]  bit_index;
   logic        busy;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int pause_lo = -1;
   int pause_hi = -2;
   int start_at = -100;
   int busy_hi  = -1;
   int busy_lo  = 1 << 30;

   int ss_t[$];
   int sh_t[$];
   int pa_t[$];
   int st_t[$];
   int pd_t[$];

   uart_bit_timer dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .abort         (abort),
      .enable_timer  (enable_timer),
      .bit_period    (bit_period),
      .data_size     (data_size),
      .parity_en     (parity_en),
      .two_stop      (two_stop),
      .start_strobe  (start_strobe),
      .shift_enable  (shift_enable),
      .parity_strobe (parity_strobe),
      .stop_strobe   (stop_strobe),
      .packet_done   (packet_done),
      .bit_index     (bit_index),
      .busy          (busy)
   );

   // free-running clock
   always #5 clk = ~clk;

   function automatic logic [4:0] exp_vec(input int k);
      logic [4:0] v;
      v = '0;
      foreach (ss_t[i]) if (ss_t[i] == k) v[4] = 1'b1;
      foreach (sh_t[i]) if (sh_t[i] == k) v[3] = 1'b1;
      foreach (pa_t[i]) if (pa_t[i] == k) v[2] = 1'b1;
      foreach (st_t[i]) if (st_t[i] == k) v[1] = 1'b1;
      foreach (pd_t[i]) if (pd_t[i] == k) v[0] = 1'b1;
      return v;
   endfunction

   function automatic int exp_idx(input int k);
      int n;
      n = 0;
      foreach (sh_t[i]) if (sh_t[i] <= k) n++;
      return n;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic clear();
      ss_t.delete();
      sh_t.delete();
      pa_t.delete();
      st_t.delete();
      pd_t.delete();
      busy_hi  = -1;
      busy_lo  = 1 << 30;
      start_at = -100;
      pause_lo = -1;
      pause_hi = -2;
   endtask

   task automatic start_frame();
      start = 1'b1;
      tick();
      cyc   = 0;
      start = 1'b0;
   endtask

   // compare every cycle from cyc to last, driving enable/start per schedule
   task automatic watch(input int last);
      while (1) begin
         chk("strobes", {start_strobe, shift_enable, parity_strobe, stop_strobe, packet_done},
             exp_vec(cyc));
         chk("bit_index", bit_index, exp_idx(cyc));
         if (cyc >= 1 && cyc <= busy_hi)
            chk("busy_high", busy, 1);
         else if (cyc >= busy_lo)
            chk("busy_low", busy, 0);
         if (cyc >= last) break;
         enable_timer = ((cyc + 1) >= pause_lo && (cyc + 1) <= pause_hi) ? 1'b0 : 1'b1;
         start        = ((cyc + 1) == start_at);
         tick();
      end
      start        = 1'b0;
      enable_timer = 1'b1;
   endtask

   initial begin
      clk          = 1'b0;
      rst          = 1'b1;
      start        = 1'b0;
      abort        = 1'b0;
      enable_timer = 1'b1;
      bit_period   = 14'd0;
      data_size    = 4'd0;
      parity_en    = 1'b0;
      two_stop     = 1'b0;
      clear();

      // reset state
      tick(); tick(); tick();
      chk("reset_strobes", {start_strobe, shift_enable, parity_strobe, stop_strobe, packet_done}, 0);
      chk("reset_bit_index", bit_index, 0);
      chk("reset_busy", busy, 0);
      rst = 1'b0;
      tick(); tick();

      // P=10 D=8 one stop; stray start mid-frame is ignored
      bit_period = 14'd10; data_size = 4'd8; parity_en = 1'b0; two_stop = 1'b0;
      clear();
      start_frame();
      ss_t = '{5};
      sh_t = '{15, 25, 35, 45, 55, 65, 75, 85};
      st_t = '{95};
      pd_t = '{95};
      busy_hi = 94; busy_lo = 96; start_at = 50;
      watch(100);

      // P=10 D=7 parity, two stops; start coincident with packet_done ignored
      data_size = 4'd7; parity_en = 1'b1; two_stop = 1'b1;
      clear();
      start_frame();
      ss_t = '{5};
      sh_t = '{15, 25, 35, 45, 55, 65, 75};
      pa_t = '{85};
      st_t = '{95, 105};
      pd_t = '{105};
      busy_hi = 104; busy_lo = 106; start_at = 105;
      watch(112);

      // P=1 clamps to 2, D=0 clamps to 1
      bit_period = 14'd1; data_size = 4'd0; parity_en = 1'b0; two_stop = 1'b0;
      clear();
      start_frame();
      ss_t = '{1};
      sh_t = '{3};
      st_t = '{5};
      pd_t = '{5};
      busy_hi = 4; busy_lo = 6;
      watch(10);

      // enable_timer low for edges 20..29 delays everything later by 10
      bit_period = 14'd10; data_size = 4'd8;
      clear();
      start_frame();
      ss_t = '{5};
      sh_t = '{15, 35, 45, 55, 65, 75, 85, 95};
      st_t = '{105};
      pd_t = '{105};
      busy_hi = 104; busy_lo = 106; pause_lo = 20; pause_hi = 29;
      watch(110);

      // abort together with start at edge 40, then a clean frame
      clear();
      start_frame();
      ss_t = '{5};
      sh_t = '{15, 25, 35};
      busy_hi = 39;
      watch(39);
      abort = 1'b1; start = 1'b1;
      tick();
      abort = 1'b0; start = 1'b0;
      clear();
      busy_lo = 41;
      watch(80);
      clear();
      start_frame();
      ss_t = '{5};
      sh_t = '{15, 25, 35, 45, 55, 65, 75, 85};
      st_t = '{95};
      pd_t = '{95};
      busy_hi = 94; busy_lo = 96;
      watch(100);

      // abort landing on a data strobe edge suppresses that strobe
      clear();
      start_frame();
      ss_t = '{5};
      busy_hi = 14;
      watch(14);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      clear();
      busy_lo = 16;
      watch(40);

      // mid-frame config change ignored; reset at 50 abandons the frame
      bit_period = 14'd10; data_size = 4'd8; parity_en = 1'b0; two_stop = 1'b0;
      clear();
      start_frame();
      ss_t = '{5};
      sh_t = '{15, 25, 35, 45};
      busy_hi = 49;
      watch(19);
      bit_period = 14'd4; data_size = 4'd2; parity_en = 1'b1;
      tick();
      watch(49);
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      clear();
      busy_lo = 51;
      watch(70);

      // next frame uses the period latched at its own start (P=4 D=2 parity)
      clear();
      start_frame();
      ss_t = '{2};
      sh_t = '{6, 10};
      pa_t = '{14};
      st_t = '{18};
      pd_t = '{18};
      busy_hi = 17; busy_lo = 19;
      watch(25);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
